// File: rtl/sound_latch_ctrl_pkg.sv
// Shared widths, defaults and helpers for the sound-command / sound-reply latch block.
package sound_latch_ctrl_pkg;

    // Width of both latches (one byte on each side)
    localparam int DATA_W       = 8;
    // Default nSDW low-pulse length in CLK cycles
    localparam int NSDW_LEN_DEF = 4;
    // Width of the nSDW pulse counter (holds 0..7)
    localparam int CNT_W        = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Next value of the nSDW pulse counter: a load always wins over the
    // running count so a retrigger restarts the pulse from full length.
    function automatic cnt_t pulse_cnt_next(
        input cnt_t cnt,
        input logic load,
        input cnt_t len
    );
        cnt_t nxt;
        if (load) begin
            nxt = len;
        end else if (cnt != {CNT_W{1'b0}}) begin
            nxt = cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            nxt = {CNT_W{1'b0}};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sound_latch_ctrl_strobe_edge.sv
// One-register strobe history with falling/rising event detection.
// The history resets to 0, so a strobe held low across reset release
// produces no falling event until it has been seen high first.
module strobe_edge
    import sound_latch_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic fall_evt,
    output logic rise_evt
);

    logic hist_q;
    logic hist_d;

    // Next history value is simply the current sample of the strobe
    always_comb begin
        hist_d = strobe;
    end

    // History register, cleared while reset is asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Events are reported in the cycle whose edge samples the new level
    always_comb begin
        fall_evt = hist_q & ~strobe;
        rise_evt = ~hist_q & strobe;
    end

endmodule

// File: rtl/sound_latch_ctrl.sv
// Sound-command latch (68k -> Z80) and sound-reply latch (Z80 -> 68k),
// with the nSDW command-written pulse that feeds the Z80 NMI logic.
module sound_latch_ctrl
    import sound_latch_ctrl_pkg::*;
#(
    parameter int NSDW_LEN = NSDW_LEN_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] M68K_DIN,
    input  logic              nSNDCMD_WR,
    input  logic              nSNDREP_RD,
    output logic [DATA_W-1:0] M68K_DOUT,
    input  logic [DATA_W-1:0] SDD_IN,
    output logic [DATA_W-1:0] SDD_OUT,
    output logic              SDD_OE,
    input  logic              nSDZ80R,
    input  logic              nSDZ80CLR,
    input  logic              nSDZ80W,
    output logic              nSDW,
    output logic              CMD_PENDING,
    output logic              REP_VALID
);

    localparam cnt_t PULSE_LEN = CNT_W'(NSDW_LEN);

    // Strobe events
    logic cmd_wr_fall_s, cmd_wr_rise_s;
    logic rep_rd_fall_s, rep_rd_rise_s;
    logic z80_rd_fall_s, z80_rd_rise_s;
    logic z80_clr_fall_s, z80_clr_rise_s;
    logic z80_wr_fall_s, z80_wr_rise_s;
    logic unused_evt_s;

    // State
    data_t cmd_reg_q, cmd_reg_d;
    data_t rep_reg_q, rep_reg_d;
    logic  cmd_pending_q, cmd_pending_d;
    logic  rep_valid_q, rep_valid_d;
    cnt_t  cnt_q, cnt_d;
    logic  nsdw_q, nsdw_d;

    strobe_edge u_cmd_wr (
        .clk      (CLK),
        .rst      (RESET),
        .strobe   (nSNDCMD_WR),
        .fall_evt (cmd_wr_fall_s),
        .rise_evt (cmd_wr_rise_s)
    );

    strobe_edge u_rep_rd (
        .clk      (CLK),
        .rst      (RESET),
        .strobe   (nSNDREP_RD),
        .fall_evt (rep_rd_fall_s),
        .rise_evt (rep_rd_rise_s)
    );

    strobe_edge u_z80_rd (
        .clk      (CLK),
        .rst      (RESET),
        .strobe   (nSDZ80R),
        .fall_evt (z80_rd_fall_s),
        .rise_evt (z80_rd_rise_s)
    );

    strobe_edge u_z80_clr (
        .clk      (CLK),
        .rst      (RESET),
        .strobe   (nSDZ80CLR),
        .fall_evt (z80_clr_fall_s),
        .rise_evt (z80_clr_rise_s)
    );

    strobe_edge u_z80_wr (
        .clk      (CLK),
        .rst      (RESET),
        .strobe   (nSDZ80W),
        .fall_evt (z80_wr_fall_s),
        .rise_evt (z80_wr_rise_s)
    );

    // Events that no latch reacts to are gathered here on purpose
    always_comb begin
        unused_evt_s = cmd_wr_rise_s | rep_rd_fall_s | z80_rd_rise_s
                     | z80_clr_rise_s | z80_wr_rise_s;
    end

    // Command latch: a 68k write beats a Z80 clear or read in the same cycle
    always_comb begin
        cmd_reg_d     = cmd_reg_q;
        cmd_pending_d = cmd_pending_q;
        if (cmd_wr_fall_s) begin
            cmd_reg_d     = M68K_DIN;
            cmd_pending_d = 1'b1;
        end else if (z80_clr_fall_s) begin
            cmd_reg_d     = 8'h00;
            cmd_pending_d = 1'b0;
        end else if (z80_rd_fall_s) begin
            cmd_pending_d = 1'b0;
        end else begin
            cmd_reg_d     = cmd_reg_q;
            cmd_pending_d = cmd_pending_q;
        end
    end

    // Reply latch: a Z80 write beats the end of a 68k read in the same cycle
    always_comb begin
        rep_reg_d   = rep_reg_q;
        rep_valid_d = rep_valid_q;
        if (z80_wr_fall_s) begin
            rep_reg_d   = SDD_IN;
            rep_valid_d = 1'b1;
        end else if (rep_rd_rise_s) begin
            rep_valid_d = 1'b0;
        end else begin
            rep_reg_d   = rep_reg_q;
            rep_valid_d = rep_valid_q;
        end
    end

    // nSDW pulse: low whenever the counter is (or is about to be) nonzero,
    // so a reload during a pulse keeps it low without a gap
    always_comb begin
        cnt_d  = pulse_cnt_next(cnt_q, cmd_wr_fall_s, PULSE_LEN);
        nsdw_d = (cnt_d == {CNT_W{1'b0}});
    end

    // State registers; reset forces nSDW high at once
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cmd_reg_q     <= 8'h00;
            rep_reg_q     <= 8'h00;
            cmd_pending_q <= 1'b0;
            rep_valid_q   <= 1'b0;
            cnt_q         <= {CNT_W{1'b0}};
            nsdw_q        <= 1'b1;
        end else begin
            cmd_reg_q     <= cmd_reg_d;
            rep_reg_q     <= rep_reg_d;
            cmd_pending_q <= cmd_pending_d;
            rep_valid_q   <= rep_valid_d;
            cnt_q         <= cnt_d;
            nsdw_q        <= nsdw_d;
        end
    end

    // Output drive: data buses and bus enable follow the latches with no delay
    always_comb begin
        SDD_OUT     = cmd_reg_q;
        SDD_OE      = ~nSDZ80R;
        M68K_DOUT   = rep_reg_q;
        nSDW        = nsdw_q;
        CMD_PENDING = cmd_pending_q;
        REP_VALID   = rep_valid_q;
    end

endmodule

// File: tb/tb_sound_latch_ctrl.sv
// Scoreboard bench for sound_latch_ctrl: expectations are queued as stimulus
// is applied and compared against the DUT once its outputs have settled.
module tb_sound_latch_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] M68K_DIN;
    logic       nSNDCMD_WR;
    logic       nSNDREP_RD;
    logic [7:0] M68K_DOUT;
    logic [7:0] SDD_IN;
    logic [7:0] SDD_OUT;
    logic       SDD_OE;
    logic       nSDZ80R;
    logic       nSDZ80CLR;
    logic       nSDZ80W;
    logic       nSDW;
    logic       CMD_PENDING;
    logic       REP_VALID;

    sound_latch_ctrl #(.NSDW_LEN(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .M68K_DIN    (M68K_DIN),
        .nSNDCMD_WR  (nSNDCMD_WR),
        .nSNDREP_RD  (nSNDREP_RD),
        .M68K_DOUT   (M68K_DOUT),
        .SDD_IN      (SDD_IN),
        .SDD_OUT     (SDD_OUT),
        .SDD_OE      (SDD_OE),
        .nSDZ80R     (nSDZ80R),
        .nSDZ80CLR   (nSDZ80CLR),
        .nSDZ80W     (nSDZ80W),
        .nSDW        (nSDW),
        .CMD_PENDING (CMD_PENDING),
        .REP_VALID   (REP_VALID)
    );

    always #5 CLK = ~CLK;

    localparam int SEL_PEND  = 0;
    localparam int SEL_SDOUT = 1;
    localparam int SEL_SDOE  = 2;
    localparam int SEL_NSDW  = 3;
    localparam int SEL_RVAL  = 4;
    localparam int SEL_DOUT  = 5;
    localparam int SEL_PULSE = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Length of the most recent completed nSDW low run, in cycles
    int run_len  = 0;
    int last_run = 0;

    // nSDW low-run monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (nSDW == 1'b0) begin
            run_len = run_len + 1;
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        logic [31:0] v;
        case (sel)
            SEL_PEND:  v = {31'd0, CMD_PENDING};
            SEL_SDOUT: v = {24'd0, SDD_OUT};
            SEL_SDOE:  v = {31'd0, SDD_OE};
            SEL_NSDW:  v = {31'd0, nSDW};
            SEL_RVAL:  v = {31'd0, REP_VALID};
            SEL_DOUT:  v = {24'd0, M68K_DOUT};
            SEL_PULSE: v = last_run;
            default:   v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait (bounded) for the end of an nSDW pulse, then let the monitor capture it
    task automatic wait_pulse_end(input string tag, input int exp_len);
        for (int i = 0; i < 20; i++) begin
            if (nSDW == 1'b1) break;
            tick();
        end
        @(negedge CLK);
        #1;
        push_exp({tag, "_nsdw_released"}, SEL_NSDW, 32'd1);
        push_exp({tag, "_pulse_len"}, SEL_PULSE, exp_len);
        drain();
    endtask

    initial begin
        RESET = 1'b1;
        M68K_DIN = 8'h00;  SDD_IN = 8'h00;
        nSNDCMD_WR = 1'b1; nSNDREP_RD = 1'b1;
        nSDZ80R = 1'b1;    nSDZ80CLR = 1'b1; nSDZ80W = 1'b1;
        repeat (3) tick();

        // Reset state
        push_exp("rst_pending", SEL_PEND,  32'd0);
        push_exp("rst_sdd_out", SEL_SDOUT, 32'h00);
        push_exp("rst_sdd_oe",  SEL_SDOE,  32'd0);
        push_exp("rst_nsdw",    SEL_NSDW,  32'd1);
        push_exp("rst_rvalid",  SEL_RVAL,  32'd0);
        push_exp("rst_dout",    SEL_DOUT,  32'h00);
        drain();
        RESET = 1'b0;
        tick(); tick();

        // Command path
        M68K_DIN = 8'hA5; nSNDCMD_WR = 1'b0; tick(); nSNDCMD_WR = 1'b1;
        push_exp("cmd_pending", SEL_PEND,  32'd1);
        push_exp("cmd_sdd_out", SEL_SDOUT, 32'hA5);
        push_exp("cmd_nsdw_lo", SEL_NSDW,  32'd0);
        drain();
        wait_pulse_end("cmd", 4);
        nSDZ80R = 1'b0; #1;
        push_exp("rd_sdd_oe_on", SEL_SDOE, 32'd1);
        drain();
        tick();
        push_exp("rd_pending_clr", SEL_PEND,  32'd0);
        push_exp("rd_sdd_out",     SEL_SDOUT, 32'hA5);
        drain();
        nSDZ80R = 1'b1; #1;
        push_exp("rd_sdd_oe_off", SEL_SDOE, 32'd0);
        drain();
        tick();

        // Retrigger during an active pulse
        M68K_DIN = 8'h11; nSNDCMD_WR = 1'b0; tick(); nSNDCMD_WR = 1'b1; tick();
        M68K_DIN = 8'h22; nSNDCMD_WR = 1'b0; tick(); nSNDCMD_WR = 1'b1;
        push_exp("retrig_sdd_out", SEL_SDOUT, 32'h22);
        drain();
        wait_pulse_end("retrig", 6);

        // Z80 read race with a command write: write wins
        M68K_DIN = 8'h44; nSNDCMD_WR = 1'b0; nSDZ80R = 1'b0; tick();
        nSNDCMD_WR = 1'b1; nSDZ80R = 1'b1;
        push_exp("rdrace_pending", SEL_PEND,  32'd1);
        push_exp("rdrace_sdd_out", SEL_SDOUT, 32'h44);
        drain();
        wait_pulse_end("rdrace", 4);

        // Z80 clear race with a command write: write wins
        M68K_DIN = 8'h3C; nSNDCMD_WR = 1'b0; nSDZ80CLR = 1'b0; tick();
        nSNDCMD_WR = 1'b1; nSDZ80CLR = 1'b1;
        push_exp("clrrace_pending", SEL_PEND,  32'd1);
        push_exp("clrrace_sdd_out", SEL_SDOUT, 32'h3C);
        drain();
        wait_pulse_end("clrrace", 4);
        nSDZ80CLR = 1'b0; tick(); nSDZ80CLR = 1'b1;
        push_exp("clr_pending", SEL_PEND,  32'd0);
        push_exp("clr_sdd_out", SEL_SDOUT, 32'h00);
        drain();
        tick();

        // Reply path, strobe held low for several cycles loads only once
        SDD_IN = 8'h7E; nSDZ80W = 1'b0; tick();
        SDD_IN = 8'h81; tick(); tick();
        push_exp("rep_valid",     SEL_RVAL, 32'd1);
        push_exp("rep_dout_held", SEL_DOUT, 32'h7E);
        drain();
        nSDZ80W = 1'b1; tick();
        nSNDREP_RD = 1'b0; tick();
        push_exp("rep_rd_low_valid", SEL_RVAL, 32'd1);
        drain();
        nSNDREP_RD = 1'b1; tick();
        push_exp("rep_rd_end_valid", SEL_RVAL, 32'd0);
        push_exp("rep_rd_end_dout",  SEL_DOUT, 32'h7E);
        drain();
        nSNDREP_RD = 1'b0; tick();
        nSNDREP_RD = 1'b1; SDD_IN = 8'h5A; nSDZ80W = 1'b0; tick(); nSDZ80W = 1'b1;
        push_exp("reprace_valid", SEL_RVAL, 32'd1);
        push_exp("reprace_dout",  SEL_DOUT, 32'h5A);
        drain();
        tick();

        // Reset in the 2nd nSDW-low cycle
        M68K_DIN = 8'hC3; nSNDCMD_WR = 1'b0; tick(); nSNDCMD_WR = 1'b1; tick();
        push_exp("midrst_nsdw_lo", SEL_NSDW, 32'd0);
        drain();
        RESET = 1'b1; #1;
        push_exp("midrst_nsdw",    SEL_NSDW,  32'd1);
        push_exp("midrst_pending", SEL_PEND,  32'd0);
        push_exp("midrst_sdd_out", SEL_SDOUT, 32'h00);
        push_exp("midrst_rvalid",  SEL_RVAL,  32'd0);
        push_exp("midrst_dout",    SEL_DOUT,  32'h00);
        drain();
        M68K_DIN = 8'h99; nSNDCMD_WR = 1'b0; tick(); tick();
        RESET = 1'b0; tick(); tick(); tick();
        push_exp("held_pending", SEL_PEND,  32'd0);
        push_exp("held_sdd_out", SEL_SDOUT, 32'h00);
        push_exp("held_nsdw",    SEL_NSDW,  32'd1);
        drain();
        nSNDCMD_WR = 1'b1; tick(); nSNDCMD_WR = 1'b0; tick(); nSNDCMD_WR = 1'b1;
        push_exp("rearm_pending", SEL_PEND,  32'd1);
        push_exp("rearm_sdd_out", SEL_SDOUT, 32'h99);
        push_exp("rearm_nsdw_lo", SEL_NSDW,  32'd0);
        drain();
        wait_pulse_end("rearm", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sound_latch_ctrl.md
SOUND_LATCH_CTRL -- requirements
Module: sound_latch_ctrl

Interface
REQ-001 SHALL have parameter NSDW_LEN, default 4, giving the nSDW low-pulse length in CLK cycles (legal range 1..7).
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Port list:
  CLK  in  1  system clock.
  RESET  in  1  asynchronous active-high reset.
  M68K_DIN  in  8  68k data-bus upper byte.
  nSNDCMD_WR  in  1  68k write strobe to the sound-command latch; active low.
  nSNDREP_RD  in  1  68k read strobe of the sound-reply latch; active low.
  M68K_DOUT  out  8  reply byte to the 68k.
  SDD_IN  in  8  Z80 data bus, write direction.
  SDD_OUT  out  8  command byte to the Z80 bus.
  SDD_OE  out  1  high while SDD_OUT drives the Z80 bus.
  nSDZ80R  in  1  Z80 port $x0-$x3 read; active low.
  nSDZ80CLR  in  1  Z80 port $x0-$x3 write (clear); active low.
  nSDZ80W  in  1  Z80 port $xC-$xF write (reply); active low.
  nSDW  out  1  command-written pulse to the Z80 NMI logic; active low.
  CMD_PENDING  out  1  command written and not yet read or cleared by the Z80.
  REP_VALID  out  1  reply written and not yet read by the 68k.

Function
REQ-004 All five strobes SHALL be sampled on CLK rising edges. A falling event is a sample of 0 after a previous sample of 1. A rising event is a sample of 1 after a previous sample of 0.
REQ-005 On a nSNDCMD_WR falling event, CMD_REG SHALL load M68K_DIN and CMD_PENDING SHALL be set to 1. In the same cycle, nSDW SHALL go to 0 and the pulse counter SHALL load NSDW_LEN.
REQ-006 While the counter is nonzero it SHALL decrement each cycle. nSDW SHALL return to 1 on the edge where the counter reaches 0, giving exactly NSDW_LEN cycles low.
REQ-007 A new command write during an active pulse SHALL overwrite CMD_REG and reload the counter. nSDW SHALL stay 0 with no glitch high.
REQ-008 SDD_OUT SHALL equal CMD_REG combinationally. SDD_OE SHALL equal ~nSDZ80R combinationally (zero latency).
REQ-009 A nSDZ80R falling event SHALL clear CMD_PENDING. CMD_REG SHALL be kept.
REQ-010 A nSDZ80CLR falling event SHALL clear both CMD_REG (to 8'h00) and CMD_PENDING.
REQ-011 On a nSDZ80W falling event, REP_REG SHALL load SDD_IN and REP_VALID SHALL be set to 1.
REQ-012 M68K_DOUT SHALL equal REP_REG combinationally. A nSNDREP_RD rising event (end of the 68k read) SHALL clear REP_VALID.
REQ-013 Simultaneous events SHALL resolve as follows:
  - Command write with Z80 clear or Z80 read in the same cycle: the write wins (new data, CMD_PENDING=1).
  - Z80 reply write with 68k read end in the same cycle: the write wins (REP_VALID=1).
REQ-014 A strobe held low continuously SHALL produce only one event.

Reset
REQ-015 While RESET=1, the block SHALL hold:
  - CMD_REG=8'h00, REP_REG=8'h00;
  - CMD_PENDING=0, REP_VALID=0;
  - nSDW=1, counter=0.
REQ-016 While RESET=1, all strobe history registers SHALL be 0. A strobe held low across reset release therefore SHALL NOT trigger a falling event until it first returns high.
REQ-017 Reset asserted mid-pulse SHALL force nSDW to 1 immediately (asynchronously), and it SHALL stay 1 after release.

Structure
REQ-018 The shared package SHALL hold the latch data width (8), the NSDW_LEN default, and the counter width (3).
REQ-019 There SHALL be one sub-module, strobe_edge (a one-register history plus falling/rising event outputs, reset to 0), instantiated once per strobe.
REQ-020 Both latches, both flags and the pulse counter SHALL live in sound_latch_ctrl. Target size is 150-250 lines of RTL.

Verification
REQ-021 Command path: write 8'hA5 via nSNDCMD_WR -> CMD_PENDING=1, SDD_OUT=8'hA5, nSDW low exactly 4 cycles. Then pulse nSDZ80R -> SDD_OE=1 during the strobe, CMD_PENDING=0, SDD_OUT still 8'hA5.
REQ-022 Retrigger: write 8'h11, then 8'h22 two cycles later -> nSDW low continuously for 6 cycles, CMD_REG=8'h22.
REQ-023 Clear race: nSDZ80CLR falling event in the same cycle as a write of 8'h3C -> CMD_REG=8'h3C, CMD_PENDING=1. A later lone CLR -> CMD_REG=8'h00, CMD_PENDING=0.
REQ-024 Reply path: Z80 writes 8'h7E via nSDZ80W -> REP_VALID=1, M68K_DOUT=8'h7E. A 68k read strobe low-then-high -> REP_VALID=0 on the rising event. A new reply coincident with that rising event -> REP_VALID stays 1.
REQ-025 Reset: assert RESET during the 2nd nSDW-low cycle -> nSDW=1 immediately and all registers at reset values. Hold nSNDCMD_WR low through release -> no command accepted until the strobe goes high and then low again.
